// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writer.
//   wb_sel_e        : source of the value written back to rd
//   F3_*            : load funct3 encodings understood by the load formatter
//   REG_CNT, REG_AW : register count and register address width
package regfile_pkg;

    localparam int REG_CNT = 32;
    localparam int REG_AW  = 5;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2,
        WB_IMM  = 2'd3
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_formatter.sv
// Combinational load-data formatter.
//   ld_data  : raw aligned 32-bit word from data memory
//   funct3   : load type (LB/LH/LW/LBU/LHU)
//   addr_lo  : byte offset of the load address
//   data     : selected and sign/zero-extended result
//   misalign : access not naturally aligned, or funct3 is not a load
module load_formatter
    import regfile_pkg::*;
(
    input  logic [31:0] ld_data,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] data,
    output logic        misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = ld_data[7:0];
            2'd1:    byte_sel = ld_data[15:8];
            2'd2:    byte_sel = ld_data[23:16];
            default: byte_sel = ld_data[31:24];
        endcase
        half_sel = addr_lo[1] ? ld_data[31:16] : ld_data[15:0];
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it
        // unassigned; a missing default here would infer a latch.
        data     = 32'h0;
        misalign = 1'b0;
        case (funct3)
            F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU: data = {24'h0, byte_sel};
            F3_LH: begin
                data     = {{16{half_sel[15]}}, half_sel};
                misalign = addr_lo[0];
            end
            F3_LHU: begin
                data     = {16'h0, half_sel};
                misalign = addr_lo[0];
            end
            F3_LW: begin
                data     = ld_data;
                misalign = (addr_lo != 2'b00);
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// MEM/WB pipeline register and register-file write-port driver.
//   i_iss_*           : decode issue (rd reservation), o_iss_stall refuses it
//   o_busy            : per-register pending-write flags for RAW stalls
//   i_mem_* / o_mem_ready : retiring instruction from MEM, valid/ready
//   i_wb_hold         : freezes the WB stage
//   o_rd_wren/addr/data : regfile write port, o_misalign pulses on a
//                       committed misaligned load, o_retire_cnt counts
//                       committed non-squashed instructions
module regfile_wb_ctrl
    import regfile_pkg::*;
#(
    parameter int CNT_W    = 2,
    parameter int RETIRE_W = 32
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_iss_valid,
    input  logic                i_iss_rd_wren,
    input  logic [REG_AW-1:0]   i_iss_rd_addr,
    output logic                o_iss_stall,
    output logic [REG_CNT-1:0]  o_busy,
    input  logic                i_mem_valid,
    output logic                o_mem_ready,
    input  logic                i_mem_squash,
    input  logic                i_mem_rd_wren,
    input  logic [REG_AW-1:0]   i_mem_rd_addr,
    input  logic [1:0]          i_mem_wb_sel,
    input  logic [31:0]         i_mem_alu_res,
    input  logic [31:0]         i_mem_pc4,
    input  logic [31:0]         i_mem_ld_data,
    input  logic [2:0]          i_mem_funct3,
    input  logic [1:0]          i_mem_addr_lo,
    input  logic                i_wb_hold,
    output logic                o_rd_wren,
    output logic [REG_AW-1:0]   o_rd_addr,
    output logic [31:0]         o_rd_data,
    output logic                o_misalign,
    output logic [RETIRE_W-1:0] o_retire_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              wb_valid, wb_squash, wb_wren, wb_misalign;
    logic [REG_AW-1:0] wb_rd;
    logic [31:0]       wb_data;
    logic [31:0]       fmt_data, cap_data;
    logic              fmt_misalign, cap_misalign;
    logic              xfer, commit, sb_inc, sb_dec;
    logic [REG_CNT-1:0] inc_hit, dec_hit;
    logic [CNT_W-1:0]  cnt [REG_CNT];

    load_formatter u_fmt (
        .ld_data  (i_mem_ld_data),
        .funct3   (i_mem_funct3),
        .addr_lo  (i_mem_addr_lo),
        .data     (fmt_data),
        .misalign (fmt_misalign)
    );

    assign o_mem_ready = !wb_valid || !i_wb_hold;
    assign xfer        = i_mem_valid && o_mem_ready;
    assign commit      = wb_valid && !i_wb_hold;

    // Squashed and misaligned instructions still release their reservation.
    assign sb_dec = commit && wb_wren && (wb_rd != '0);

    // A commit to the same rd this cycle frees a slot, so a saturated
    // counter does not refuse the issue.
    assign o_iss_stall = i_iss_valid && i_iss_rd_wren && (i_iss_rd_addr != '0)
                       && (cnt[i_iss_rd_addr] == CNT_MAX)
                       && !(sb_dec && (wb_rd == i_iss_rd_addr));
    assign sb_inc = i_iss_valid && i_iss_rd_wren && (i_iss_rd_addr != '0) && !o_iss_stall;

    assign o_rd_wren  = commit && wb_wren && !wb_squash && (wb_rd != '0) && !wb_misalign;
    assign o_misalign = commit && wb_misalign && !wb_squash;
    assign o_rd_addr  = wb_rd;
    assign o_rd_data  = wb_data;

    always_comb begin
        cap_data     = i_mem_alu_res;
        cap_misalign = 1'b0;
        case (wb_sel_e'(i_mem_wb_sel))
            WB_LOAD: begin
                cap_data     = fmt_data;
                cap_misalign = fmt_misalign;
            end
            WB_PC4:  cap_data = i_mem_pc4;
            default: ;  // ALU and IMM both arrive on alu_res
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wb_valid    <= 1'b0;
            wb_squash   <= 1'b0;
            wb_wren     <= 1'b0;
            wb_misalign <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= 32'h0;
        end else if (xfer) begin
            wb_valid    <= 1'b1;
            wb_squash   <= i_mem_squash;
            wb_wren     <= i_mem_rd_wren;
            wb_misalign <= cap_misalign;
            wb_rd       <= i_mem_rd_addr;
            wb_data     <= cap_data;
        end else if (commit) begin
            wb_valid <= 1'b0;
        end
    end

    always_comb begin
        inc_hit = '0;
        dec_hit = '0;
        inc_hit[i_iss_rd_addr] = sb_inc;
        dec_hit[wb_rd]         = sb_dec;
    end

    // NOTE: the counter array is flop-based and must be cleared by reset so no
    // stale reservation survives; it is not a RAM and cannot be left unreset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < REG_CNT; r++) cnt[r] <= '0;
        end else begin
            // Entry 0 never sees a hit, so it stays at zero.
            for (int r = 0; r < REG_CNT; r++) begin
                if (inc_hit[r] && !dec_hit[r])
                    cnt[r] <= cnt[r] + CNT_W'(1);
                else if (dec_hit[r] && !inc_hit[r] && (cnt[r] != '0))
                    cnt[r] <= cnt[r] - CNT_W'(1);
            end
        end
    end

    always_comb begin
        o_busy = '0;
        for (int r = 1; r < REG_CNT; r++) o_busy[r] = (cnt[r] != '0);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_retire_cnt <= '0;
        else if (commit && !wb_squash)
            o_retire_cnt <= o_retire_cnt + RETIRE_W'(1);
    end

    // Releasing an idle counter means a write retired that decode never issued.
    a_no_underflow : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(sb_dec && (cnt[wb_rd] == '0)));

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: a queue of expected commits is
// filled on every MEM transfer and drained on every commit cycle.
module tb_regfile_wb_ctrl;
    import regfile_pkg::*;

    localparam int CNT_MAX = 3;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_iss_valid, i_iss_rd_wren;
    logic [4:0]  i_iss_rd_addr;
    logic        o_iss_stall;
    logic [31:0] o_busy;
    logic        i_mem_valid, o_mem_ready, i_mem_squash, i_mem_rd_wren;
    logic [4:0]  i_mem_rd_addr;
    logic [1:0]  i_mem_wb_sel;
    logic [31:0] i_mem_alu_res, i_mem_pc4, i_mem_ld_data;
    logic [2:0]  i_mem_funct3;
    logic [1:0]  i_mem_addr_lo;
    logic        i_wb_hold;
    logic        o_rd_wren;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data;
    logic        o_misalign;
    logic [31:0] o_retire_cnt;

    regfile_wb_ctrl #(.CNT_W(2), .RETIRE_W(32)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_iss_valid(i_iss_valid), .i_iss_rd_wren(i_iss_rd_wren),
        .i_iss_rd_addr(i_iss_rd_addr), .o_iss_stall(o_iss_stall), .o_busy(o_busy),
        .i_mem_valid(i_mem_valid), .o_mem_ready(o_mem_ready),
        .i_mem_squash(i_mem_squash), .i_mem_rd_wren(i_mem_rd_wren),
        .i_mem_rd_addr(i_mem_rd_addr), .i_mem_wb_sel(i_mem_wb_sel),
        .i_mem_alu_res(i_mem_alu_res), .i_mem_pc4(i_mem_pc4),
        .i_mem_ld_data(i_mem_ld_data), .i_mem_funct3(i_mem_funct3),
        .i_mem_addr_lo(i_mem_addr_lo), .i_wb_hold(i_wb_hold),
        .o_rd_wren(o_rd_wren), .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data),
        .o_misalign(o_misalign), .o_retire_cnt(o_retire_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        wren;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        misalign;
        logic        dec;
        logic        retire;
    } exp_t;

    exp_t        exp_q[$];
    int          cnt_m [32];
    logic [31:0] retire_m;
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    // {misalign, data} for a load, written from the load-type table.
    function automatic logic [32:0] fmt_model(input logic [31:0] w, input logic [2:0] f3,
                                              input logic [1:0] lo);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (8 * lo));
        h = lo[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {1'b0, {{24{b[7]}}, b}};
            3'b100:  return {1'b0, 24'h0, b};
            3'b001:  return {lo[0], {{16{h[15]}}, h}};
            3'b101:  return {lo[0], 16'h0, h};
            3'b010:  return {(lo != 2'b00), w};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    function automatic exp_t make_exp();
        exp_t        x;
        logic [32:0] f;
        x.rd       = i_mem_rd_addr;
        x.retire   = !i_mem_squash;
        x.dec      = i_mem_rd_wren && (i_mem_rd_addr != 5'd0);
        x.misalign = 1'b0;
        case (i_mem_wb_sel)
            2'd1: begin
                f          = fmt_model(i_mem_ld_data, i_mem_funct3, i_mem_addr_lo);
                x.data     = f[31:0];
                x.misalign = f[32];
            end
            2'd2:    x.data = i_mem_pc4;
            default: x.data = i_mem_alu_res;
        endcase
        x.wren     = i_mem_rd_wren && !i_mem_squash && (i_mem_rd_addr != 5'd0) && !x.misalign;
        x.misalign = x.misalign && !i_mem_squash;
        return x;
    endfunction

    task automatic idle();
        i_iss_valid = 0; i_iss_rd_wren = 0; i_iss_rd_addr = 0;
        i_mem_valid = 0; i_mem_squash = 0; i_mem_rd_wren = 0; i_mem_rd_addr = 0;
        i_mem_wb_sel = 0; i_mem_alu_res = 0; i_mem_pc4 = 0; i_mem_ld_data = 0;
        i_mem_funct3 = 0; i_mem_addr_lo = 0;
    endtask

    task automatic iss(input logic [4:0] rd);
        i_iss_valid = 1; i_iss_rd_wren = 1; i_iss_rd_addr = rd;
    endtask

    task automatic mem(input logic sq, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] ld,
                       input logic [2:0] f3, input logic [1:0] lo);
        i_mem_valid = 1; i_mem_squash = sq; i_mem_rd_wren = 1; i_mem_rd_addr = rd;
        i_mem_wb_sel = sel; i_mem_alu_res = alu; i_mem_pc4 = 32'h0000_1004;
        i_mem_ld_data = ld; i_mem_funct3 = f3; i_mem_addr_lo = lo;
    endtask

    // Called at a falling edge with inputs driven; returns at the next falling edge.
    task automatic tick();
        exp_t        e;
        logic        occ, commit_m, ready_m, xfer, dec_hit, stall_m;
        logic [31:0] busy_m;
        e = '{wren: 0, rd: 0, data: 0, misalign: 0, dec: 0, retire: 0};
        #1;
        occ      = (exp_q.size() > 0);
        commit_m = occ && !i_wb_hold;
        ready_m  = !(occ && i_wb_hold);
        check("mem_ready", o_mem_ready, ready_m);
        if (commit_m) begin
            e = exp_q[0];
            check("rd_wren", o_rd_wren, e.wren);
            if (e.wren) begin
                check("rd_addr", o_rd_addr, e.rd);
                check("rd_data", o_rd_data, e.data);
            end
            check("misalign", o_misalign, e.misalign);
        end else begin
            check("rd_wren_idle", o_rd_wren, 1'b0);
            check("misalign_idle", o_misalign, 1'b0);
            if (occ) begin
                check("hold_addr", o_rd_addr, exp_q[0].rd);
                if (!exp_q[0].misalign) check("hold_data", o_rd_data, exp_q[0].data);
            end
        end
        dec_hit = commit_m && e.dec && (e.rd == i_iss_rd_addr);
        stall_m = i_iss_valid && i_iss_rd_wren && (i_iss_rd_addr != 5'd0)
                  && (cnt_m[i_iss_rd_addr] == CNT_MAX) && !dec_hit;
        check("iss_stall", o_iss_stall, stall_m);
        busy_m = 32'h0;
        for (int r = 1; r < 32; r++) busy_m[r] = (cnt_m[r] != 0);
        check("busy", o_busy, busy_m);
        check("retire_cnt", o_retire_cnt, retire_m);
        xfer = i_mem_valid && ready_m;
        @(posedge i_clk);
        if (commit_m) begin
            void'(exp_q.pop_front());
            if (e.dec) cnt_m[e.rd]--;
            if (e.retire) retire_m++;
        end
        if (i_iss_valid && i_iss_rd_wren && (i_iss_rd_addr != 5'd0) && !stall_m)
            cnt_m[i_iss_rd_addr]++;
        if (xfer) exp_q.push_back(make_exp());
        @(negedge i_clk);
    endtask

    task automatic clear_model();
        exp_q.delete();
        for (int r = 0; r < 32; r++) cnt_m[r] = 0;
        retire_m = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_model();
        idle();
        i_wb_hold = 0;
        i_rst_n   = 0;
        #12;
        check("rst_rd_wren", o_rd_wren, 1'b0);
        check("rst_rd_addr", o_rd_addr, 5'd0);
        check("rst_rd_data", o_rd_data, 32'h0);
        check("rst_misalign", o_misalign, 1'b0);
        check("rst_retire", o_retire_cnt, 32'h0);
        check("rst_busy", o_busy, 32'h0);
        check("rst_stall", o_iss_stall, 1'b0);
        @(negedge i_clk);
        i_rst_n = 1;

        // ALU write to x5, two edges from accept to regfile update
        idle(); iss(5); tick();
        idle(); mem(0, 5, 2'd0, 32'h1234_5678, 0, 0, 0); tick();
        idle(); #1;
        check("t1_wren", o_rd_wren, 1'b1);
        check("t1_data", o_rd_data, 32'h1234_5678);
        check("t1_busy5", o_busy[5], 1'b1);
        tick();
        idle(); tick();
        check("t1_retire", o_retire_cnt, 32'd1);
        check("t1_busy5_clr", o_busy[5], 1'b0);

        // Load formatting: LB, LHU, misaligned LW
        idle(); iss(10); tick();
        idle(); iss(11); mem(0, 10, 2'd1, 0, 32'h80FF_0000, 3'b000, 2'd3); tick();
        idle(); iss(12); mem(0, 11, 2'd1, 0, 32'h80FF_0000, 3'b101, 2'd2); #1;
        check("lb_data", o_rd_data, 32'hFFFF_FF80);
        tick();
        idle(); mem(0, 12, 2'd1, 0, 32'h80FF_0000, 3'b010, 2'd1); #1;
        check("lhu_data", o_rd_data, 32'h0000_80FF);
        tick();
        idle(); #1;
        check("lw_misalign", o_misalign, 1'b1);
        check("lw_no_wren", o_rd_wren, 1'b0);
        tick();
        idle(); tick();
        check("lw_busy12_clr", o_busy[12], 1'b0);

        // PC+4 and IMM selects
        idle(); iss(13); tick();
        idle(); iss(14); mem(0, 13, 2'd2, 32'hAAAA_0000, 0, 0, 0); tick();
        idle(); mem(0, 14, 2'd3, 32'h0000_0ABC, 0, 0, 0); tick();
        idle(); tick();
        idle(); tick();

        // Squashed instruction: releases x9, no write, no retire
        idle(); iss(9); tick();
        idle(); mem(1, 9, 2'd0, 32'h0000_0055, 0, 0, 0); tick();
        idle(); tick();
        idle(); tick();

        // Write to x0 is dropped but retires
        idle(); mem(0, 0, 2'd0, 32'hDEAD_BEEF, 0, 0, 0); tick();
        idle(); #1;
        check("x0_no_wren", o_rd_wren, 1'b0);
        tick();
        idle(); tick();
        check("x0_busy0", o_busy[0], 1'b0);

        // Saturate x7, then free a slot on the same cycle as an issue
        for (int k = 0; k < 3; k++) begin
            idle(); iss(7); tick();
        end
        idle(); iss(7); #1;
        check("x7_sat_stall", o_iss_stall, 1'b1);
        tick();
        idle(); iss(7); mem(0, 7, 2'd0, 32'h0000_0070, 0, 0, 0); tick();
        idle(); iss(7); #1;
        check("x7_release_stall", o_iss_stall, 1'b0);
        tick();
        idle(); iss(7); #1;
        check("x7_still_full", o_iss_stall, 1'b1);
        tick();
        for (int k = 0; k < 3; k++) begin
            idle(); mem(0, 7, 2'd0, 32'h0000_0071 + k, 0, 0, 0); tick();
        end
        idle(); tick();
        idle(); tick();

        // WB hold with MEM waiting, then back-to-back drain
        idle(); iss(20); tick();
        idle(); iss(21); tick();
        idle(); iss(22); tick();
        idle(); mem(0, 20, 2'd0, 32'hA000_0020, 0, 0, 0); tick();
        i_wb_hold = 1;
        for (int k = 0; k < 3; k++) begin
            idle(); mem(0, 21, 2'd0, 32'hB000_0021, 0, 0, 0); tick();
        end
        i_wb_hold = 0;
        idle(); mem(0, 21, 2'd0, 32'hB000_0021, 0, 0, 0); tick();
        idle(); mem(0, 22, 2'd0, 32'hC000_0022, 0, 0, 0); tick();
        idle(); tick();
        idle(); tick();

        // Asynchronous reset with a live WB entry and a pending x3
        idle(); iss(3); tick();
        idle(); mem(0, 3, 2'd0, 32'h0000_0333, 0, 0, 0); tick();
        idle(); #1;
        check("pre_rst_busy3", o_busy[3], 1'b1);
        #1;
        i_rst_n = 0;
        #1;
        check("mid_rst_busy", o_busy, 32'h0);
        check("mid_rst_wren", o_rd_wren, 1'b0);
        check("mid_rst_retire", o_retire_cnt, 32'h0);
        clear_model();
        @(negedge i_clk);
        i_rst_n = 1;
        idle(); tick();
        idle(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
